alu_rr_arbiter: RTL
===================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational 32b ALU among NUM_REQ requesters. Round-robin arbitration, one op in flight.
//  Operands and op_ctl are registered toward the ALU; result and flags are registered back into a response channel.
//  Sits between the issue logic (requesters) and the ALU; the ALU instance stays outside this block.
// PARAMETERS
//  NUM_REQ   4                     number of requesters (2..8)
//  ID_W      $clog2(NUM_REQ)       width of rsp_id
// PORTS
//  clk           in   1             single clock, rising edge
//  rst_n         in   1             asynchronous, active-low reset
//  req_valid     in   NUM_REQ       per-requester request valid
//  req_ready     out  NUM_REQ       per-requester accept; one-hot or zero
//  req_a         in   NUM_REQ*32    operand A, requester i at [32i+:32]
//  req_b         in   NUM_REQ*32    operand B, same packing
//  req_op        in   NUM_REQ*11    op_ctl {shamt[10:6], ctl[5:0]}, requester i at [11i+:11]
//  alu_a         out  32            registered operand A to ALU
//  alu_b         out  32            registered operand B to ALU
//  alu_op_ctl    out  11            registered op_ctl to ALU
//  alu_z         in   32            ALU result
//  alu_overflow  in   1             ALU overflow flag
//  alu_zero      in   1             ALU zero flag
//  alu_carryout  in   1             ALU carryout flag
//  rsp_valid     out  1             response valid
//  rsp_ready     in   1             response accept
//  rsp_id        out  ID_W          index of the requester that issued the op
//  rsp_z         out  32            captured result
//  rsp_flags     out  3             {overflow, carryout, zero}
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, and all outputs 0 (req_ready, alu_*, rsp_*).
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: grant = first valid requester searching from rr_ptr upward with wrap.
//    req_ready[grant]=1 combinationally in the same cycle; all other bits are 0.
//    On accept: latch A/B/op into the alu_* registers, latch grant into id_q, rr_ptr <= (grant+1) mod NUM_REQ, go to EXEC.
//  - EXEC (1 cycle): the ALU settles. Capture alu_z and the three flags into rsp_* at the clock edge. rsp_valid <= 1. Go to RESP.
//  - RESP: rsp_* held stable until rsp_valid && rsp_ready. Then rsp_valid <= 0 and go to IDLE.
//  - Latency: accept at edge N; rsp_valid is high from N+2. Without the optional feature, a new accept occurs one cycle after the rsp handshake at the earliest.
//  - req_ready is 0 in EXEC and RESP. Requesters must not gate req_valid on req_ready.
//  - rr_ptr changes only on accept. No valid requests means no grant and rr_ptr unchanged.
//  - alu_* hold their last values outside EXEC; they are not cleared after use.
//  - Flags pass through unmodified. Overflow is only meaningful for add/sub (ctl[5]=1, ctl[3:2]=00); the block does not mask it.
//  - A reset asserted in any state discards the in-flight op with no response; all outputs return to reset values asynchronously.
// CONFIGURATION
//  ALU_ARB_BACK2BACK_EN defined:
//    In RESP, on the rsp handshake cycle the arbiter also evaluates requests.
//    On accept it goes directly RESP -> EXEC, giving 2 cycles per op. req_ready may be high in RESP only in that handshake cycle.
//  Undefined: RESP always returns to IDLE, giving 3 cycles per op minimum.
// STRUCTURE
//  alu_arb_pkg:
//    state enum {IDLE, EXEC, RESP}
//    OP_W=11, SHAMT_LSB=6
//    flag indices FLG_ZERO=0, FLG_COUT=1, FLG_OVF=2
//  Sub-module alu_rr_pick: combinational round-robin picker (req_valid, rr_ptr -> grant_vld, grant_idx).
// TESTING
//  1 Single op: req0 A=5, B=7, op=0x020 (add) -> rsp at accept+2: rsp_id=0, rsp_z=12, rsp_flags=3'b000.
//  2 Zero: req2 A=B=0x00001234, op=0x022 (sub) -> rsp_z=0, rsp_flags[0]=1, rsp_id=2.
//  3 Overflow: req1 A=0x7FFFFFFF, B=1, op=0x020 -> rsp_z=0x80000000, rsp_flags[2]=1.
//  4 Contention: all 4 req_valid held high from reset -> rsp_id sequence 0,1,2,3,0; each op exactly 3 cycles (2 with _EN).
//  5 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, no further alu_* update.
//  6 Reset mid-EXEC: rst_n low with op in flight -> rsp_valid=0 with no response; after release, req3 alone is granted and rsp_id=3.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the round-robin ALU arbiter
//   state_t        : arbiter FSM states
//   OP_W/SHAMT_LSB : op_ctl layout {shamt[10:6], ctl[5:0]}
//   FLG_*          : bit positions inside rsp_flags {overflow, carryout, zero}
package alu_arb_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int OP_W      = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FLG_ZERO  = 0;
    localparam int FLG_COUT  = 1;
    localparam int FLG_OVF   = 2;
endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin picker, first valid at or above rr_ptr with wrap
//   req_valid : per-requester valid
//   rr_ptr    : highest-priority index
//   grant_vld : some requester is valid
//   grant_idx : chosen requester (0 when none)
module alu_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_valid,
    input  logic [W-1:0] rr_ptr,
    output logic         grant_vld,
    output logic [W-1:0] grant_idx
);
    logic [W-1:0] idx;
    // Scan from the lowest priority down so the last hit is the closest to rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((32'(rr_ptr) + 32'(k)) % N);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external 32b ALU among NUM_REQ requesters, round-robin, one op in flight
//   Optional macro ALU_ARB_BACK2BACK_EN: arbitrate again in the response-handshake cycle (2 cycles/op).
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : per-requester handshake, req_ready one-hot or zero
//   req_a/req_b/req_op          : packed operands and op_ctl, requester i at [32i+:32] / [11i+:11]
//   alu_a/alu_b/alu_op_ctl      : registered operands toward the ALU
//   alu_z/alu_overflow/alu_zero/alu_carryout : ALU result and flags
//   rsp_valid/rsp_ready         : response handshake
//   rsp_id/rsp_z/rsp_flags      : issuing requester, result, {overflow, carryout, zero}
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [OP_W-1:0]         alu_op_ctl,
    input  logic [31:0]             alu_z,
    input  logic                    alu_overflow,
    input  logic                    alu_zero,
    input  logic                    alu_carryout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_z,
    output logic [2:0]              rsp_flags
);
    state_t          state;
    logic [ID_W-1:0] rr_ptr, id_q, grant_idx;
    logic            grant_vld, arb_en, accept;

    alu_rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // rst_n gates arbitration so req_ready drops to 0 while reset is held.
`ifdef ALU_ARB_BACK2BACK_EN
    assign arb_en = rst_n && ((state == IDLE) || (state == RESP && rsp_ready));
`else
    assign arb_en = rst_n && (state == IDLE);
`endif
    assign accept    = arb_en && grant_vld;
    assign req_ready = accept ? NUM_REQ'(1) << grant_idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_ctl <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_z      <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                alu_a      <= req_a[32*grant_idx +: 32];
                alu_b      <= req_b[32*grant_idx +: 32];
                alu_op_ctl <= req_op[OP_W*grant_idx +: OP_W];
                id_q       <= grant_idx;
                rr_ptr     <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
            case (state)
                IDLE: state <= accept ? EXEC : IDLE;
                EXEC: begin
                    rsp_z               <= alu_z;
                    rsp_flags[FLG_OVF]  <= alu_overflow;
                    rsp_flags[FLG_COUT] <= alu_carryout;
                    rsp_flags[FLG_ZERO] <= alu_zero;
                    rsp_id              <= id_q;
                    rsp_valid           <= 1'b1;
                    state               <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= accept ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
